// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for the IF/DE/MW pipeline: sequences
// multi-cycle data-memory waits, traps, mret and taken branches.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_taken,
    input  logic             rd_enMW,
    input  logic             wr_enMW,
    input  logic             is_mret_MW,
    input  logic             irq_pending,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             mw_en,
    output logic             mw_flush,
    output logic [1:0]       pc_sel,
    output logic             trap_take,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

    localparam logic [1:0]       SEL_PC4   = 2'b00;
    localparam logic [1:0]       SEL_BR    = 2'b01;
    localparam logic [1:0]       SEL_MTVEC = 2'b10;
    localparam logic [1:0]       SEL_MEPC  = 2'b11;
    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [7:0]       wait_cnt, wait_nxt;
    logic [CNT_W-1:0] stall_nxt;
    logic             mem_req;
    logic             run_evt;

    assign mem_req = rd_enMW | wr_enMW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        mw_en     = 1'b1;
        fd_flush  = 1'b0;
        mw_flush  = 1'b0;
        pc_sel    = SEL_PC4;
        trap_take = 1'b0;
        mem_fault = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        stall_nxt = stall_cnt;
        run_evt   = 1'b0;

        unique case (state)
            RUN: begin
                if (mem_req && !dmem_ack) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    mw_en     = 1'b0;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                    stall_nxt = stall_cnt + CNT_ONE;
                end else begin
                    run_evt = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    wait_nxt = 8'd0;
                    run_evt  = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Timeout: abandon the access and vector to the trap handler
                    mem_fault = 1'b1;
                    trap_take = 1'b1;
                    pc_sel    = SEL_MTVEC;
                    fd_flush  = 1'b1;
                    mw_flush  = 1'b1;
                    state_nxt = TRAP;
                    wait_nxt  = 8'd0;
                    stall_nxt = stall_cnt + CNT_ONE;
                end else begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    mw_en     = 1'b0;
                    wait_nxt  = wait_cnt + 8'd1;
                    stall_nxt = stall_cnt + CNT_ONE;
                end
            end
            TRAP: begin
                // DE holds a flushed NOP and MIE is being updated: only memory matters
                if (mem_req && !dmem_ack) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    mw_en     = 1'b0;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                    stall_nxt = stall_cnt + CNT_ONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (run_evt) begin
            state_nxt = RUN;
            if (irq_pending) begin
                trap_take = 1'b1;
                pc_sel    = SEL_MTVEC;
                fd_flush  = 1'b1;
                mw_flush  = 1'b1;
                state_nxt = TRAP;
            end else if (is_mret_MW) begin
                pc_sel   = SEL_MEPC;
                fd_flush = 1'b1;
                mw_flush = 1'b1;
            end else if (br_taken) begin
                pc_sel   = SEL_BR;
                fd_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            mw_en     = 1'b0;
            fd_flush  = 1'b1;
            mw_flush  = 1'b1;
            pc_sel    = SEL_PC4;
            trap_take = 1'b0;
            mem_fault = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // {pc_en, fd_en, fd_flush, mw_en, mw_flush, pc_sel[1:0], trap_take, mem_fault}
    localparam logic [8:0] DEF = 9'b1_1_0_1_0_00_0_0;
    localparam logic [8:0] FRZ = 9'b0_0_0_0_0_00_0_0;
    localparam logic [8:0] RST = 9'b0_0_1_0_1_00_0_0;
    localparam logic [8:0] TRP = 9'b1_1_1_1_1_10_1_0;
    localparam logic [8:0] FLT = 9'b1_1_1_1_1_10_1_1;
    localparam logic [8:0] MRT = 9'b1_1_1_1_1_11_0_0;
    localparam logic [8:0] BRT = 9'b1_1_1_1_0_01_0_0;

    typedef struct {
        logic [8:0]       outs;
        logic             chk_stall;
        logic [CNT_W-1:0] stall;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             br_taken = 1'b0, rd_enMW = 1'b0, wr_enMW = 1'b0;
    logic             is_mret_MW = 1'b0, irq_pending = 1'b0, dmem_ack = 1'b0;
    logic             pc_en, fd_en, fd_flush, mw_en, mw_flush, trap_take, mem_fault;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] stall_cnt;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .br_taken(br_taken), .rd_enMW(rd_enMW),
        .wr_enMW(wr_enMW), .is_mret_MW(is_mret_MW), .irq_pending(irq_pending),
        .dmem_ack(dmem_ack), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
        .mw_en(mw_en), .mw_flush(mw_flush), .pc_sel(pc_sel), .trap_take(trap_take),
        .mem_fault(mem_fault), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {pc_en, fd_en, fd_flush, mw_en, mw_flush, pc_sel, trap_take, mem_fault};
            n_tests++;
            if (act !== e.outs) begin
                n_fail++;
                $display("FAIL %s outs: got %b expected %b", e.name, act, e.outs);
            end
            if (e.chk_stall) begin
                n_tests++;
                if (stall_cnt !== e.stall) begin
                    n_fail++;
                    $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.stall);
                end
            end
        end
    end

    task automatic vec(input logic r, input logic br, input logic rd, input logic wr,
                       input logic mret, input logic irq, input logic ack,
                       input logic [8:0] outs, input logic chk, input int stall,
                       input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; br_taken = br; rd_enMW = rd; wr_enMW = wr;
        is_mret_MW = mret; irq_pending = irq; dmem_ack = ack;
        e.outs = outs; e.chk_stall = chk; e.stall = CNT_W'(stall); e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        //   rst br rd wr mr irq ack  outs chk stall
        vec(1, 1, 1, 1, 1, 1, 1, RST, 0, 0,  "reset0");
        vec(1, 1, 1, 1, 1, 1, 1, RST, 1, 0,  "reset1");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 0,  "idle_after_reset");

        // load acked on the 4th cycle: 3 frozen cycles
        vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 0,  "load_frz1");
        vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 1,  "load_frz2");
        vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 2,  "load_frz3");
        vec(0, 0, 1, 0, 0, 0, 1, DEF, 1, 3,  "load_ack");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 3,  "load_done");

        vec(0, 1, 0, 0, 1, 0, 0, MRT, 0, 0,  "br_and_mret");
        vec(0, 1, 0, 0, 0, 0, 0, BRT, 0, 0,  "br_only");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 3,  "idle2");

        // irq held 4 cycles: trap, ignored, trap, ignored
        vec(0, 0, 0, 0, 0, 1, 0, TRP, 0, 0,  "irq_c0");
        vec(0, 0, 0, 0, 0, 1, 0, DEF, 0, 0,  "irq_c1_trapstate");
        vec(0, 0, 0, 0, 0, 1, 0, TRP, 0, 0,  "irq_c2");
        vec(0, 0, 0, 0, 0, 1, 0, DEF, 0, 0,  "irq_c3_trapstate");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 3,  "idle3");

        // irq alongside a completing access; TRAP ignores irq and branch
        vec(0, 0, 1, 0, 0, 1, 1, TRP, 0, 0,  "irq_with_ack");
        vec(0, 1, 0, 0, 0, 1, 0, DEF, 0, 0,  "trap_ignores_br_irq");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 3,  "idle4");

        // memory stall beginning in TRAP, release applies branch rule
        vec(0, 0, 0, 0, 0, 1, 0, TRP, 0, 0,  "irq_again");
        vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 3,  "trap_mem_frz");
        vec(0, 1, 1, 0, 0, 0, 1, BRT, 1, 4,  "release_br");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 4,  "idle5");

        // release with irq goes to TRAP
        vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 4,  "wait_frz");
        vec(0, 0, 1, 0, 0, 1, 1, TRP, 1, 5,  "release_irq");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 0, 0,  "post_release_trap");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 5,  "idle6");

        // store never acked: 15 frozen cycles then fault
        vec(0, 0, 0, 1, 0, 0, 0, FRZ, 1, 5,  "store_frz_run");
        for (int i = 0; i < 14; i++)
            vec(0, 0, 0, 1, 0, 0, 0, FRZ, 1, 6 + i, "store_frz_wait");
        vec(0, 0, 0, 1, 0, 0, 0, FLT, 1, 20, "store_timeout");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 21, "after_fault_trap");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 21, "idle7");

        // reset during the 5th MEM_WAIT cycle abandons the access
        vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 21, "rst_wait_entry");
        for (int i = 0; i < 4; i++)
            vec(0, 0, 1, 0, 0, 0, 0, FRZ, 1, 22 + i, "rst_wait_frz");
        vec(1, 0, 1, 0, 0, 0, 0, RST, 1, 26, "rst_mid_wait");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 0,  "after_mid_reset");
        vec(0, 0, 0, 0, 0, 0, 0, DEF, 1, 0,  "idle8");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect controller for the 3-stage (IF, DE, MW) pipeline.
- Drives the enable and flush inputs of the IF/DE and DE/MW pipeline buffers, including the DE/MW control buffer.
- Drives the PC enable and the PC source select.
- Sequences multi-cycle data-memory accesses, taken branches/jumps, interrupt entry and mret return; maintains a stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for dmem_ack before a memory fault is raised; legal range 2..255.
- CNT_W, 32: stall counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- br_taken  input  1  branch/jump resolved taken in DE.
- rd_enMW  input  1  load in MW (from DE/MW control buffer).
- wr_enMW  input  1  store in MW.
- is_mret_MW  input  1  mret in MW.
- irq_pending  input  1  enabled interrupt pending (from CSR file).
- dmem_ack  input  1  data memory completes the current access this cycle.
- pc_en  output  1  PC register enable.
- fd_en  output  1  IF/DE buffer enable.
- fd_flush  output  1  IF/DE buffer loads NOP on next edge.
- mw_en  output  1  DE/MW buffers enable.
- mw_flush  output  1  DE/MW buffers load NOP (all control bits 0) on next edge.
- pc_sel  output  2  00 pc+4, 01 branch target, 10 mtvec, 11 mepc.
- trap_take  output  1  one-cycle pulse; CSR file saves mepc/mcause.
- mem_fault  output  1  one-cycle pulse on dmem timeout.
- stall_cnt  output  CNT_W  cycles spent in MEM_WAIT since reset.

Behaviour:
- The reset interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: while rst=1, outputs are forced to pc_en=0, fd_en=0, mw_en=0, fd_flush=1, mw_flush=1, pc_sel=00, trap_take=0, mem_fault=0. On the edge: state<=RUN, wait_cnt<=0, stall_cnt<=0. Reset asserted mid-MEM_WAIT abandons the access.
- mem_req = rd_enMW | wr_enMW.
- Outputs are combinational from state and inputs; state, wait_cnt and stall_cnt are registered.
- Default (no event): pc_en=fd_en=mw_en=1, flushes=0, pc_sel=00.
- State RUN: evaluate events in priority order; the first match wins.
  1. mem_req & !dmem_ack:
     - Freeze: pc_en=fd_en=mw_en=0, all other outputs default.
     - next=MEM_WAIT, wait_cnt<=1, stall_cnt+=1.
     - irq and branch are ignored this cycle.
  2. irq_pending:
     - trap_take=1, pc_sel=10, fd_flush=1, mw_flush=1, pc_en=1; next=TRAP.
     - This is valid even with mem_req & dmem_ack: the MW access has completed, and the MW writeback still occurs this cycle.
  3. is_mret_MW:
     - pc_sel=11, fd_flush=1, mw_flush=1; next=RUN.
  4. br_taken:
     - pc_sel=01, fd_flush=1; mw_en=1, mw_flush=0 (the branch itself proceeds); next=RUN.
- State MEM_WAIT:
  - dmem_ack=1:
    - Release: the RUN rules are applied to the same cycle's inputs, excluding rule 1.
    - next=RUN, or TRAP if irq was taken.
    - wait_cnt<=0.
  - Else if wait_cnt==MEM_TIMEOUT-1:
    - mem_fault=1, trap_take=1, pc_sel=10, fd_flush=1, mw_flush=1, pc_en=1.
    - next=TRAP, stall_cnt+=1.
  - Else:
    - Freeze as in rule 1.
    - wait_cnt+=1, stall_cnt+=1.
- State TRAP (exactly 1 cycle; gives the CSR file time to update MIE):
  - Default outputs apply, except that irq_pending is ignored and br_taken is ignored (the DE slot holds a flushed NOP).
  - mem_req is still honoured as in rule 1; next=MEM_WAIT or RUN.
- stall_cnt wraps from all-ones to 0 silently. wait_cnt is 8 bits.
- Simultaneity:
  - fd_flush and fd_en may both be 1: flush wins, and the buffer loads NOP.
  - mw_flush overrides mw_en the same way.
  - Freeze never coincides with any flush.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all inputs high -> pc_en=0, fd_flush=mw_flush=1, stall_cnt=0; first cycle after release with no events -> pc_en=fd_en=mw_en=1, pc_sel=00.
- Load with dmem_ack after 3 cycles -> pc_en=fd_en=mw_en=0 for exactly 3 cycles, release on the ack cycle, stall_cnt=3.
- br_taken=1 and is_mret_MW=1 in the same RUN cycle -> pc_sel=11, fd_flush=1, mw_flush=1 (mret wins); br_taken alone -> pc_sel=01, fd_flush=1, mw_flush=0.
- irq_pending held high for 4 cycles -> one trap_take pulse, pc_sel=10, both flushes; TRAP cycle ignores irq; a second trap_take occurs 2 cycles after the first if irq is still high.
- Store with no ack, MEM_TIMEOUT=16 -> freeze for 15 cycles; cycle 16 gives mem_fault=trap_take=1, pc_sel=10; stall_cnt=16.
- rst asserted during the 5th MEM_WAIT cycle -> next cycle state RUN, stall_cnt=0, no mem_fault pulse.
